// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-organised RAM with byte strobes, range
// checking (SLVERR) and programmable read/write wait states.
module axi_lite_mem_slave #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned RD_WAIT    = 0,
   parameter int unsigned WR_WAIT    = 0
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [STRB_WIDTH-1:0] WSTRB,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RVALID,
   input  logic                  RREADY
);

   localparam int unsigned OFF_W = $clog2(STRB_WIDTH);
   localparam int unsigned MA_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_ADDR_WAIT, W_DATA_WAIT, W_STALL, W_RESP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_STALL, R_DATA} rstate_e;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return 64'(a >> OFF_W) < 64'(MEM_DEPTH);
   endfunction

   function automatic logic [MA_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return MA_W'(a >> OFF_W);
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   wstate_e               wstate_q, wstate_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  aw_hs_c, w_hs_c, aw_have_c, w_have_c, wr_commit_c, mem_we_c;

   rstate_e               rstate_q, rstate_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [CNT_W-1:0]      rcnt_q, rcnt_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  ar_hs_c, rd_commit_c;

   assign aw_hs_c   = AWVALID & awready_q;
   assign w_hs_c    = WVALID & wready_q;
   assign aw_have_c = aw_hs_c | (wstate_q == W_DATA_WAIT);
   assign w_have_c  = w_hs_c | (wstate_q == W_ADDR_WAIT);
   assign ar_hs_c   = ARVALID & arready_q;

   // Write channel: gather AW and W in either order, optional stall, then respond
   always_comb begin : wr_next
      wstate_d    = wstate_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wcnt_d      = wcnt_q;
      bresp_d     = bresp_q;
      wr_commit_c = 1'b0;
      if (aw_hs_c) awaddr_d = AWADDR;
      if (w_hs_c) begin
         wdata_d = WDATA;
         wstrb_d = WSTRB;
      end
      unique case (wstate_q)
         W_IDLE, W_ADDR_WAIT, W_DATA_WAIT: begin
            if (aw_have_c && w_have_c) begin
               if (WR_WAIT == 0) begin
                  wstate_d    = W_RESP;
                  wr_commit_c = 1'b1;
               end else begin
                  wstate_d = W_STALL;
                  wcnt_d   = CNT_W'(WR_WAIT - 1);
               end
            end else if (aw_have_c) begin
               wstate_d = W_DATA_WAIT;
            end else if (w_have_c) begin
               wstate_d = W_ADDR_WAIT;
            end
         end
         W_STALL: begin
            if (wcnt_q == '0) begin
               wstate_d    = W_RESP;
               wr_commit_c = 1'b1;
            end else begin
               wcnt_d = wcnt_q - CNT_W'(1);
            end
         end
         W_RESP:  if (BREADY) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
      if (wr_commit_c) bresp_d = in_range(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
      awready_d = (wstate_d == W_IDLE) || (wstate_d == W_ADDR_WAIT);
      wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_DATA_WAIT);
      bvalid_d  = (wstate_d == W_RESP);
   end

   assign mem_we_c = wr_commit_c & in_range(awaddr_d);

   // Read channel: optional stall, memory sampled on the edge entering R_DATA
   always_comb begin : rd_next
      rstate_d    = rstate_q;
      araddr_d    = araddr_q;
      rcnt_d      = rcnt_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rd_commit_c = 1'b0;
      if (ar_hs_c) araddr_d = ARADDR;
      unique case (rstate_q)
         R_IDLE: begin
            if (ar_hs_c) begin
               if (RD_WAIT == 0) begin
                  rstate_d    = R_DATA;
                  rd_commit_c = 1'b1;
               end else begin
                  rstate_d = R_STALL;
                  rcnt_d   = CNT_W'(RD_WAIT - 1);
               end
            end
         end
         R_STALL: begin
            if (rcnt_q == '0) begin
               rstate_d    = R_DATA;
               rd_commit_c = 1'b1;
            end else begin
               rcnt_d = rcnt_q - CNT_W'(1);
            end
         end
         R_DATA:  if (RREADY) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
      if (rd_commit_c) begin
         rdata_d = in_range(araddr_d) ? mem_q[word_idx(araddr_d)] : '0;
         rresp_d = in_range(araddr_d) ? RESP_OKAY : RESP_SLVERR;
      end
      arready_d = (rstate_d == R_IDLE);
      rvalid_d  = (rstate_d == R_DATA);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin : state_regs
      if (!ARESETN) begin
         wstate_q  <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wcnt_q    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rstate_q  <= R_IDLE;
         araddr_q  <= '0;
         rcnt_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         wstate_q  <= wstate_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wcnt_q    <= wcnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rstate_q  <= rstate_d;
         araddr_q  <= araddr_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // RAM contents survive reset; byte lanes gated by the captured strobes
   always_ff @(posedge ACLK) begin : mem_write
      if (mem_we_c) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_d[b]) mem_q[word_idx(awaddr_d)][b*8 +: 8] <= wdata_d[b*8 +: 8];
         end
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: two instances (no wait states / RD_WAIT=3,WR_WAIT=2),
// directed vector table, corner-case sequences and a randomized model comparison.
module tb_axi_lite_mem_slave;
   localparam int unsigned AW = 13;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, sel;
   logic [AW-1:0] awaddr, araddr;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          awvalid_m, wvalid_m, bready_m, arvalid_m, rready_m;

   logic awready0, wready0, bvalid0, arready0, rvalid0;
   logic awready1, wready1, bvalid1, arready1, rvalid1;
   logic [1:0]  bresp0, rresp0, bresp1, rresp1;
   logic [31:0] rdata0, rdata1;
   logic awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   assign awready = sel ? awready1 : awready0;
   assign wready  = sel ? wready1  : wready0;
   assign bvalid  = sel ? bvalid1  : bvalid0;
   assign arready = sel ? arready1 : arready0;
   assign rvalid  = sel ? rvalid1  : rvalid0;
   assign bresp   = sel ? bresp1   : bresp0;
   assign rresp   = sel ? rresp1   : rresp0;
   assign rdata   = sel ? rdata1   : rdata0;

   axi_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                        .RD_WAIT(0), .WR_WAIT(0)) u0 (
      .ACLK(clk), .ARESETN(rst_n),
      .AWADDR(awaddr), .AWVALID(awvalid_m & ~sel), .AWREADY(awready0),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid_m & ~sel), .WREADY(wready0),
      .BRESP(bresp0), .BVALID(bvalid0), .BREADY(bready_m & ~sel),
      .ARADDR(araddr), .ARVALID(arvalid_m & ~sel), .ARREADY(arready0),
      .RDATA(rdata0), .RRESP(rresp0), .RVALID(rvalid0), .RREADY(rready_m & ~sel));

   axi_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                        .RD_WAIT(3), .WR_WAIT(2)) u1 (
      .ACLK(clk), .ARESETN(rst_n),
      .AWADDR(awaddr), .AWVALID(awvalid_m & sel), .AWREADY(awready1),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid_m & sel), .WREADY(wready1),
      .BRESP(bresp1), .BVALID(bvalid1), .BREADY(bready_m & sel),
      .ARADDR(araddr), .ARVALID(arvalid_m & sel), .ARREADY(arready1),
      .RDATA(rdata1), .RRESP(rresp1), .RVALID(rvalid1), .RREADY(rready_m & sel));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // AW valid from cycle aw_at, W valid from cycle w_at; BREADY held low b_hold cycles
   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_at, input int w_at, input int b_hold,
                           output logic [1:0] resp, output int lat);
      bit aw_done, w_done, aw_fire, w_fire;
      int cyc;
      aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid_m = !aw_done && (cyc >= aw_at);
         wvalid_m  = !w_done && (cyc >= w_at);
         aw_fire   = awvalid_m && awready;
         w_fire    = wvalid_m && wready;
         tick();
         cyc++;
         aw_done |= aw_fire;
         w_done  |= w_fire;
      end
      awvalid_m = 1'b0;
      wvalid_m  = 1'b0;
      check("wr_handshakes", 64'(aw_done && w_done), 64'(1));
      lat = 1;
      while (!bvalid && lat < 40) begin
         tick();
         lat++;
      end
      check("bvalid_seen", 64'(bvalid), 64'(1));
      resp = bresp;
      for (int i = 0; i < b_hold; i++) begin
         tick();
         check("b_held", 64'({bvalid, bresp}), 64'({1'b1, resp}));
      end
      bready_m = 1'b1;
      tick();
      bready_m = 1'b0;
      check("b_done_rdy", 64'({bvalid, awready, wready}), 64'(3'b011));
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int r_hold,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
      int c;
      c = 0;
      araddr = a;
      arvalid_m = 1'b1;
      while (!arready && c < 40) begin
         tick();
         c++;
      end
      check("arready_seen", 64'(arready), 64'(1));
      tick();
      arvalid_m = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin
         tick();
         lat++;
      end
      check("rvalid_seen", 64'(rvalid), 64'(1));
      d = rdata;
      resp = rresp;
      for (int i = 0; i < r_hold; i++) begin
         tick();
         check("r_held", 64'({rvalid, rresp, rdata}), 64'({1'b1, resp, d}));
      end
      rready_m = 1'b1;
      tick();
      rready_m = 1'b0;
      check("r_done_rdy", 64'({rvalid, arready}), 64'(2'b01));
   endtask

   typedef struct {
      bit          wr;
      logic [AW-1:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] model [2][16];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [1:0]  resp;
      logic [31:0] d, mask, exp_d;
      logic [3:0]  st;
      logic [AW-1:0] a;
      int          lat, rl, bl, w;
      bit          oor;

      vecs[0]  = '{1'b1, 13'h010,  32'hDEADBEEF, 4'hF, OKAY,   32'h0};
      vecs[1]  = '{1'b0, 13'h010,  32'h0,        4'h0, OKAY,   32'hDEADBEEF};
      vecs[2]  = '{1'b1, 13'h010,  32'h11223344, 4'h5, OKAY,   32'h0};
      vecs[3]  = '{1'b0, 13'h010,  32'h0,        4'h0, OKAY,   32'hDE22BE44};
      vecs[4]  = '{1'b1, 13'h000,  32'hCAFEF00D, 4'hF, OKAY,   32'h0};
      vecs[5]  = '{1'b1, 13'h1000, 32'h12345678, 4'hF, SLVERR, 32'h0};
      vecs[6]  = '{1'b0, 13'h1000, 32'h0,        4'h0, SLVERR, 32'h0};
      vecs[7]  = '{1'b0, 13'h000,  32'h0,        4'h0, OKAY,   32'hCAFEF00D};
      vecs[8]  = '{1'b1, 13'h013,  32'hFFFFFFFF, 4'h0, OKAY,   32'h0};
      vecs[9]  = '{1'b0, 13'h012,  32'h0,        4'h0, OKAY,   32'hDE22BE44};
      vecs[10] = '{1'b1, 13'h1FFC, 32'h0BADBEEF, 4'hC, SLVERR, 32'h0};
      vecs[11] = '{1'b0, 13'h003,  32'h0,        4'h0, OKAY,   32'hCAFEF00D};

      rst_n = 1'b0; sel = 1'b0;
      awvalid_m = 1'b0; wvalid_m = 1'b0; bready_m = 1'b0; arvalid_m = 1'b0; rready_m = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

      // Reset values, then READYs rise on the first edge after release
      #12;
      check("rst_u0", 64'({awready0, wready0, arready0, bvalid0, rvalid0, bresp0, rresp0, rdata0}), 64'(0));
      check("rst_u1", 64'({awready1, wready1, arready1, bvalid1, rvalid1, bresp1, rresp1, rdata1}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("rdy_before_edge", 64'({awready0, wready0, arready0}), 64'(0));
      tick();
      check("rdy_after_edge_u0", 64'({awready0, wready0, arready0}), 64'(3'b111));
      check("rdy_after_edge_u1", 64'({awready1, wready1, arready1}), 64'(3'b111));

      // Directed vectors on the zero-wait instance
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, lat);
            check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].resp));
            check($sformatf("vec%0d_wlat", i), 64'(lat), 64'(1));
         end else begin
            do_read(vecs[i].addr, 0, d, resp, lat);
            check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].resp));
            check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].rdata));
            check($sformatf("vec%0d_rlat", i), 64'(lat), 64'(1));
         end
      end

      // W three cycles ahead of AW, BREADY withheld for four cycles
      do_write(13'h044, 32'h0BADF00D, 4'hF, 3, 0, 4, resp, lat);
      check("w_first_bresp", 64'(resp), 64'(OKAY));
      do_read(13'h044, 2, d, resp, lat);
      check("w_first_rdata", 64'(d), 64'(32'h0BADF00D));

      // Reset asserted while waiting for W after AW: outputs clear at once, RAM kept
      do_write(13'h030, 32'h55AA55AA, 4'hF, 0, 0, 0, resp, lat);
      awaddr = 13'h030; wdata = 32'h99999999; wstrb = 4'hF;
      awvalid_m = 1'b1;
      tick();
      awvalid_m = 1'b0;
      check("data_wait_rdy", 64'({awready, wready}), 64'(2'b01));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_u0", 64'({awready0, wready0, arready0, bvalid0, rvalid0, bresp0, rresp0, rdata0}), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_rdy", 64'({awready0, wready0, arready0}), 64'(3'b111));
      do_read(13'h030, 0, d, resp, lat);
      check("post_rst_rdata", 64'(d), 64'(32'h55AA55AA));

      // Wait-state instance: read and write of one word committing on the same edge
      sel = 1'b1;
      do_write(13'h020, 32'h0, 4'hF, 0, 0, 0, resp, lat);
      check("ws_init_lat", 64'(lat), 64'(3));
      araddr = 13'h020;
      arvalid_m = 1'b1;
      check("ws_arready", 64'(arready), 64'(1));
      tick();
      arvalid_m = 1'b0;
      awaddr = 13'h020; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
      awvalid_m = 1'b1; wvalid_m = 1'b1;
      check("ws_awwready", 64'({awready, wready}), 64'(2'b11));
      tick();
      awvalid_m = 1'b0; wvalid_m = 1'b0;
      rl = -1; bl = -1;
      for (int k = 1; k <= 8; k++) begin
         if (bvalid && bl < 0) bl = k;
         if (rvalid && rl < 0) rl = k + 1;
         if (bl < 0 || rl < 0) tick();
      end
      check("ws_rlat", 64'(rl), 64'(4));
      check("ws_blat", 64'(bl), 64'(3));
      check("ws_rdata_prewrite", 64'({rresp, rdata}), 64'({OKAY, 32'h0}));
      check("ws_bresp", 64'(bresp), 64'(OKAY));
      bready_m = 1'b1; rready_m = 1'b1;
      tick();
      bready_m = 1'b0; rready_m = 1'b0;
      check("ws_done", 64'({bvalid, rvalid}), 64'(0));
      do_read(13'h020, 0, d, resp, lat);
      check("ws_readback", 64'(d), 64'(32'hA5A5A5A5));
      check("ws_readback_lat", 64'(lat), 64'(4));

      // Random traffic against an array model of the first sixteen words
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         for (int k = 0; k < 16; k++) begin
            d = $urandom;
            model[s][k] = d;
            do_write(AW'(k * 4), d, 4'hF, 0, 0, 0, resp, lat);
            check("rnd_init_bresp", 64'(resp), 64'(OKAY));
         end
         for (int n = 0; n < 60; n++) begin
            oor = ($urandom_range(0, 7) == 0);
            w = $urandom_range(0, 15);
            a = oor ? AW'(32'h1000 + $urandom_range(0, 32'hFFF)) : AW'(w * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
               d  = $urandom;
               st = 4'($urandom_range(0, 15));
               do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, lat);
               check($sformatf("rnd%0d_%0d_bresp", s, n), 64'(resp), 64'(oor ? SLVERR : OKAY));
               check($sformatf("rnd%0d_%0d_wlat", s, n), 64'(lat), 64'(s == 1 ? 3 : 1));
               if (!oor) begin
                  mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
                  model[s][w] = (model[s][w] & ~mask) | (d & mask);
               end
            end else begin
               do_read(a, $urandom_range(0, 2), d, resp, lat);
               exp_d = oor ? 32'h0 : model[s][w];
               check($sformatf("rnd%0d_%0d_rresp", s, n), 64'(resp), 64'(oor ? SLVERR : OKAY));
               check($sformatf("rnd%0d_%0d_rdata", s, n), 64'(d), 64'(exp_d));
               check($sformatf("rnd%0d_%0d_rlat", s, n), 64'(lat), 64'(s == 1 ? 4 : 1));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
